mod_n_detect: RTL and testbench
===============================

# mod_n_detect

Parametrised serial divisibility detector: it consumes a number one radix-2^DIGIT_W digit per accepted cycle and reports, after every digit, the running remainder modulo DIVISOR and whether the number received so far is divisible by DIVISOR. It generalises the fixed divide-by-5, 1-bit serial FSM in three ways: arbitrary divisor, multi-bit digits, and a valid/clear handshake. It sits on serial data paths as a streaming checker ahead of status/flag logic.

## Interface
- DIVISOR, 5: modulus; legal range 2..2^16.
- DIGIT_W, 1: bits per digit; legal range 1..8. Radix is 2^DIGIT_W.
- CNT_W, 16: width of the digit counter.
- REM_W (derived, not overridable): clog2(DIVISOR).
- clk  in  1  single clock; everything is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous restart of the number.
- din_valid  in  1  din carries a digit this cycle.
- din  in  DIGIT_W  digit value; MSB-first by default.
- dout  out  1  number so far is divisible by DIVISOR; registered.
- dout_valid  out  1  at least one digit has been accepted since reset/clr.
- rem  out  REM_W  running remainder, always in 0..DIVISOR-1.
- digit_cnt  out  CNT_W  digits accepted; saturating.
- cnt_sat  out  1  digit_cnt has reached all-ones.

## Operation
- States:
  - EMPTY: no digits accepted yet.
  - ACTIVE: one or more digits accepted.
- Reset values: state=EMPTY, rem=0, dout=0, dout_valid=0, digit_cnt=0, cnt_sat=0.
- A digit is accepted on a rising edge when din_valid=1.
- MSB-first step: rem' = (rem·2^DIGIT_W + din) mod DIVISOR.
  - The intermediate value is REM_W+DIGIT_W bits wide and must be reduced exactly, with no truncation.
- dout' = (rem' == 0). dout_valid' = 1.
- State transitions:
  - EMPTY→ACTIVE on an accepted digit.
  - Any state→EMPTY on clr with din_valid=0.
- clr and din_valid together in the same cycle: the old number is discarded and din becomes the first digit of a new number.
  - rem' = din mod DIVISOR.
  - digit_cnt' = 1.
  - State goes to ACTIVE.
- clr alone: all outputs return to their reset values, synchronously.
- din_valid=0 and clr=0: all registers hold.
- digit_cnt increments per accepted digit and saturates at 2^CNT_W−1. cnt_sat is set at saturation and stays set until clr or reset.
  - Saturation does not affect rem or dout; the remainder stays exact for unbounded streams.
- Leading zero digits are legal: rem stays 0 and dout=1.

## Timing
- Latency is 1 cycle: a digit accepted at edge k is reflected in rem, dout, dout_valid and digit_cnt immediately after edge k.
- Throughput is one digit per cycle, with no back-pressure.
- reset_n asserted mid-stream clears everything immediately, asynchronously. The first digit after deassertion is treated as the first digit of a new number.
- All outputs are driven straight from registers; there is no combinational input-to-output path.

## Configuration
- Macro MOD_N_DETECT_LSB_FIRST_EN.
- Undefined: MSB-first arithmetic as described under Operation.
- Defined: LSB-first arithmetic.
  - Adds a weight register w, REM_W bits wide. w = 1 mod DIVISOR on reset, on clr alone, and at the start of a new number.
  - Per accepted digit: rem' = (rem + din·w) mod DIVISOR, then w' = (w·2^DIGIT_W) mod DIVISOR.
  - clr together with din_valid: rem' = din mod DIVISOR, and w' = 2^DIGIT_W mod DIVISOR.
  - All other behaviour, ports and timing are unchanged.

## Structure
- Package mod_n_pkg holds:
  - the state enum (EMPTY, ACTIVE);
  - a constant function computing REM_W;
  - a pure function mod_reduce(value, divisor) shared by both arithmetic modes.
- One sub-module, mod_n_step: the purely combinational single-digit remainder update (and the weight update in LSB mode).
  - It is instantiated once.
  - It is separately unit-testable against a reference model.
- The top level holds the state register, digit counter and output registers.

## Test plan
- DIVISOR=5, DIGIT_W=1, MSB-first, digits 1,0,1,0 → rem 1,2,0,0; dout 0,0,1,1; digit_cnt 4.
- DIVISOR=3, DIGIT_W=4, digits 0x1, 0x2 (0x12=18) → rem 1 then 0; dout=1; a further digit 0x1 (0x121=289) → rem 1, dout=0.
- MOD_N_DETECT_LSB_FIRST_EN defined, DIVISOR=5, DIGIT_W=1, digits LSB-first 0,1,0,1 (value 10) → rem 0,2,2,0; dout=1 after the fourth digit.
- After any stream, clr=1 with din_valid=1 and din=1 → next cycle rem=1, digit_cnt=1, dout=0, dout_valid=1. Then clr alone → rem=0, dout_valid=0, digit_cnt=0.
- reset_n pulsed low mid-stream (between digits 2 and 3) → outputs go to reset values asynchronously; digits 1,0,1 after release → rem=0, dout=1 (DIVISOR=5). Gaps with din_valid=0 inserted between digits → outputs unchanged during each gap.
- CNT_W=3, DIVISOR=7, DIGIT_W=1: nine digits 1 (value 511) → digit_cnt=7, cnt_sat=1, rem=0, dout=1.

Source files
------------

// File: rtl/mod_n_detect_pkg.sv
// mod_n_pkg: shared types and helpers for the mod_n_detect serial
// divisibility detector.
//   state_e     : detector state (EMPTY / ACTIVE)
//   rem_width   : width of the running remainder for a given divisor
//   mod_reduce  : exact modulo reduction used by both arithmetic modes
package mod_n_pkg;

  typedef enum logic [0:0] {
    EMPTY  = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Remainder width; a divisor of 2 still needs one bit.
  function automatic int rem_width(input int divisor);
    return (divisor <= 2) ? 1 : $clog2(divisor);
  endfunction

  // Operands are at most REM_W+DIGIT_W+1 <= 25 bits, so 32 bits keeps
  // the reduction exact in every legal configuration.
  function automatic logic [31:0] mod_reduce(input logic [31:0] value,
                                             input logic [31:0] divisor);
    return value % divisor;
  endfunction

endpackage

// File: rtl/mod_n_detect_if.sv
// mod_n_detect_if: digit stream in, divisibility status out.
//   master : drives clr, din_valid, din; observes status
//   slave  : the detector
// Handshake: a digit is taken on every rising edge where din_valid=1;
// there is no ready, the detector always accepts. clr with din_valid
// starts a new number with din as its first digit; clr alone empties.
interface mod_n_detect_if #(
  parameter int DIVISOR = 5,
  parameter int DIGIT_W = 1,
  parameter int CNT_W   = 16
) ();
  localparam int REM_W = mod_n_pkg::rem_width(DIVISOR);

  logic               clr;
  logic               din_valid;
  logic [DIGIT_W-1:0] din;
  logic               dout;
  logic               dout_valid;
  logic [REM_W-1:0]   rem;
  logic [CNT_W-1:0]   digit_cnt;
  logic               cnt_sat;
  mod_n_pkg::state_e  dbg_state;

  modport master (
    output clr, din_valid, din,
    input  dout, dout_valid, rem, digit_cnt, cnt_sat, dbg_state
  );

  modport slave (
    input  clr, din_valid, din,
    output dout, dout_valid, rem, digit_cnt, cnt_sat, dbg_state
  );
endinterface

// File: rtl/mod_n_detect_step.sv
// mod_n_step: combinational single-digit remainder update.
//   rem_in  : remainder before this digit (0 for the first digit)
//   din     : incoming digit
//   rem_out : remainder after this digit
//   w_in/w_out (MOD_N_DETECT_LSB_FIRST_EN only): weight of this digit
//             and of the next one, both reduced mod DIVISOR.
// Default build is MSB-first; defining MOD_N_DETECT_LSB_FIRST_EN
// switches to LSB-first arithmetic.
module mod_n_step
  import mod_n_pkg::*;
#(
  parameter int DIVISOR = 5,
  parameter int DIGIT_W = 1,
  localparam int REM_W  = rem_width(DIVISOR)
) (
  input  logic [REM_W-1:0]   rem_in,
`ifdef MOD_N_DETECT_LSB_FIRST_EN
  input  logic [REM_W-1:0]   w_in,
  output logic [REM_W-1:0]   w_out,
`endif
  input  logic [DIGIT_W-1:0] din,
  output logic [REM_W-1:0]   rem_out
);

`ifdef MOD_N_DETECT_LSB_FIRST_EN
  // rem' = (rem + din*w) mod D ; w' = (w * 2^DIGIT_W) mod D
  assign rem_out = REM_W'(mod_reduce(32'(rem_in) + 32'(din) * 32'(w_in),
                                     32'(DIVISOR)));
  assign w_out   = REM_W'(mod_reduce(32'(w_in) << DIGIT_W, 32'(DIVISOR)));
`else
  // rem' = (rem * 2^DIGIT_W + din) mod D; the shift leaves the low
  // DIGIT_W bits clear, so OR-ing the digit in is an exact add.
  assign rem_out = REM_W'(mod_reduce((32'(rem_in) << DIGIT_W) | 32'(din),
                                     32'(DIVISOR)));
`endif

endmodule

// File: rtl/mod_n_detect.sv
// mod_n_detect: streaming divisibility detector. Takes one radix
// 2^DIGIT_W digit per cycle with din_valid and reports the running
// remainder mod DIVISOR and whether the number so far is divisible.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : clr/din_valid/din in; dout, dout_valid, rem,
//                  digit_cnt, cnt_sat, dbg_state out (all registered)
// Optional macro MOD_N_DETECT_LSB_FIRST_EN selects LSB-first digits.
module mod_n_detect
  import mod_n_pkg::*;
#(
  parameter int DIVISOR = 5,
  parameter int DIGIT_W = 1,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  mod_n_detect_if.slave bus
);

  localparam int REM_W = rem_width(DIVISOR);

  localparam logic [0:0] ST_EMPTY  = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]       state_q;
  logic [REM_W-1:0] rem_q;
  logic             dout_q;
  logic             dout_valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_sat_q;

  logic [REM_W-1:0] rem_base;
  logic [REM_W-1:0] rem_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // clr with a digit restarts the number: the digit is applied to an
  // empty remainder (and unit weight in LSB mode).
  assign rem_base = bus.clr ? '0 : rem_q;

  // Saturating counter; a restart makes this digit the first.
  assign cnt_nxt = bus.clr ? CNT_W'(1)
                 : (&cnt_q) ? cnt_q
                 : cnt_q + CNT_W'(1);

`ifdef MOD_N_DETECT_LSB_FIRST_EN
  localparam logic [REM_W-1:0] W_ONE = REM_W'(1);

  logic [REM_W-1:0] w_q;
  logic [REM_W-1:0] w_base;
  logic [REM_W-1:0] w_nxt;

  assign w_base = bus.clr ? W_ONE : w_q;

  mod_n_step #(.DIVISOR(DIVISOR), .DIGIT_W(DIGIT_W)) u_step (
    .rem_in  (rem_base),
    .w_in    (w_base),
    .w_out   (w_nxt),
    .din     (bus.din),
    .rem_out (rem_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_q <= W_ONE;
    end else if (bus.din_valid) begin
      w_q <= w_nxt;
    end else if (bus.clr) begin
      w_q <= W_ONE;
    end
  end
`else
  mod_n_step #(.DIVISOR(DIVISOR), .DIGIT_W(DIGIT_W)) u_step (
    .rem_in  (rem_base),
    .din     (bus.din),
    .rem_out (rem_nxt)
  );
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_EMPTY;
      rem_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      cnt_q        <= '0;
      cnt_sat_q    <= 1'b0;
    end else if (bus.din_valid) begin
      state_q      <= ST_ACTIVE;
      rem_q        <= rem_nxt;
      dout_q       <= (rem_nxt == '0);
      dout_valid_q <= 1'b1;
      cnt_q        <= cnt_nxt;
      // The counter never leaves all-ones except via clr/reset, so
      // this keeps cnt_sat sticky.
      cnt_sat_q    <= &cnt_nxt;
    end else if (bus.clr) begin
      state_q      <= ST_EMPTY;
      rem_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      cnt_q        <= '0;
      cnt_sat_q    <= 1'b0;
    end
  end

  assign bus.rem        = rem_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.digit_cnt  = cnt_q;
  assign bus.cnt_sat    = cnt_sat_q;
  assign bus.dbg_state  = state_e'(state_q);

endmodule

// File: tb/tb_mod_n_detect.sv
// tb_mod_n_detect: directed bench for mod_n_detect with three
// configurations: D=5/W=1, D=3/W=4 and D=7/W=1 with a 3-bit counter.
module tb_mod_n_detect;
  import mod_n_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mod_n_detect_if #(.DIVISOR(5), .DIGIT_W(1), .CNT_W(16)) if5 ();
  mod_n_detect_if #(.DIVISOR(3), .DIGIT_W(4), .CNT_W(16)) if3 ();
  mod_n_detect_if #(.DIVISOR(7), .DIGIT_W(1), .CNT_W(3))  if7 ();

  mod_n_detect #(.DIVISOR(5), .DIGIT_W(1), .CNT_W(16)) u5 (
    .clk(clk), .reset_n(reset_n), .bus(if5.slave));
  mod_n_detect #(.DIVISOR(3), .DIGIT_W(4), .CNT_W(16)) u3 (
    .clk(clk), .reset_n(reset_n), .bus(if3.slave));
  mod_n_detect #(.DIVISOR(7), .DIGIT_W(1), .CNT_W(3)) u7 (
    .clk(clk), .reset_n(reset_n), .bus(if7.slave));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each drive task applies inputs for one edge and returns 1 time
  // unit after it, when the registered outputs are settled.
  task automatic cyc5(input logic c, input logic v, input logic d);
    if5.clr = c; if5.din_valid = v; if5.din = d;
    @(posedge clk); #1;
    if5.clr = 1'b0; if5.din_valid = 1'b0;
  endtask

  task automatic cyc3(input logic c, input logic v, input logic [3:0] d);
    if3.clr = c; if3.din_valid = v; if3.din = d;
    @(posedge clk); #1;
    if3.clr = 1'b0; if3.din_valid = 1'b0;
  endtask

  task automatic cyc7(input logic c, input logic v, input logic d);
    if7.clr = c; if7.din_valid = v; if7.din = d;
    @(posedge clk); #1;
    if7.clr = 1'b0; if7.din_valid = 1'b0;
  endtask

  initial begin
    if5.clr = 1'b0; if5.din_valid = 1'b0; if5.din = '0;
    if3.clr = 1'b0; if3.din_valid = 1'b0; if3.din = '0;
    if7.clr = 1'b0; if7.din_valid = 1'b0; if7.din = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rem", 32'(if5.rem), 0);
    chk("rst_dout", 32'(if5.dout), 0);
    chk("rst_dv", 32'(if5.dout_valid), 0);
    chk("rst_cnt", 32'(if5.digit_cnt), 0);
    chk("rst_sat", 32'(if5.cnt_sat), 0);
    chk("rst_state", 32'(if5.dbg_state), 32'(EMPTY));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

`ifdef MOD_N_DETECT_LSB_FIRST_EN
    // LSB-first 0,1,0,1 = 10
    cyc5(0, 1, 0); chk("lsb_d1_rem", 32'(if5.rem), 0);
    cyc5(0, 1, 1); chk("lsb_d2_rem", 32'(if5.rem), 2);
    cyc5(0, 1, 0); chk("lsb_d3_rem", 32'(if5.rem), 2);
    cyc5(0, 1, 1); chk("lsb_d4_rem", 32'(if5.rem), 0);
    chk("lsb_d4_dout", 32'(if5.dout), 1);
`else
    // MSB-first 1,0,1,0 = 10
    cyc5(0, 1, 1); chk("msb_d1_rem", 32'(if5.rem), 1);
    chk("msb_d1_dout", 32'(if5.dout), 0);
    chk("msb_d1_state", 32'(if5.dbg_state), 32'(ACTIVE));
    cyc5(0, 1, 0); chk("msb_d2_rem", 32'(if5.rem), 2);
    chk("msb_d2_dout", 32'(if5.dout), 0);
    cyc5(0, 1, 1); chk("msb_d3_rem", 32'(if5.rem), 0);
    chk("msb_d3_dout", 32'(if5.dout), 1);
    cyc5(0, 1, 0); chk("msb_d4_rem", 32'(if5.rem), 0);
    chk("msb_d4_dout", 32'(if5.dout), 1);
`endif
    chk("d4_cnt", 32'(if5.digit_cnt), 4);
    chk("d4_dv", 32'(if5.dout_valid), 1);

    // Idle cycle holds everything
    cyc5(0, 0, 1);
    chk("gap_rem", 32'(if5.rem), 0);
    chk("gap_cnt", 32'(if5.digit_cnt), 4);

    // clr with a digit restarts
    cyc5(1, 1, 1);
    chk("clrv_rem", 32'(if5.rem), 1);
    chk("clrv_cnt", 32'(if5.digit_cnt), 1);
    chk("clrv_dout", 32'(if5.dout), 0);
    chk("clrv_dv", 32'(if5.dout_valid), 1);

    // clr alone empties
    cyc5(1, 0, 1);
    chk("clr_rem", 32'(if5.rem), 0);
    chk("clr_dv", 32'(if5.dout_valid), 0);
    chk("clr_cnt", 32'(if5.digit_cnt), 0);
    chk("clr_state", 32'(if5.dbg_state), 32'(EMPTY));

    // Leading zero digit: divisible
    cyc5(0, 1, 0);
    chk("lz_rem", 32'(if5.rem), 0);
    chk("lz_dout", 32'(if5.dout), 1);

    // Asynchronous reset mid-stream: 1,1 (rem 1 then 3 either order)
    cyc5(1, 1, 1);
    cyc5(0, 0, 0);
    cyc5(0, 1, 1);
    chk("pre_rst_rem", 32'(if5.rem), 3);
    cyc5(0, 0, 1);
    chk("gap2_rem", 32'(if5.rem), 3);
    chk("gap2_cnt", 32'(if5.digit_cnt), 2);
    reset_n = 1'b0;
    #1;
    chk("arst_rem", 32'(if5.rem), 0);
    chk("arst_cnt", 32'(if5.digit_cnt), 0);
    chk("arst_dv", 32'(if5.dout_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    cyc5(0, 1, 1);
    cyc5(0, 0, 0);
    cyc5(0, 1, 0);
    cyc5(0, 1, 1);
    chk("post_rst_rem", 32'(if5.rem), 0);
    chk("post_rst_dout", 32'(if5.dout), 1);
    chk("post_rst_cnt", 32'(if5.digit_cnt), 3);

    // Radix 16, D=3: 0x1, 0x2 (18), 0x1 (289)
    cyc3(0, 1, 4'h1); chk("r16_d1_rem", 32'(if3.rem), 1);
    cyc3(0, 1, 4'h2); chk("r16_d2_rem", 32'(if3.rem), 0);
    chk("r16_d2_dout", 32'(if3.dout), 1);
    cyc3(0, 1, 4'h1); chk("r16_d3_rem", 32'(if3.rem), 1);
    chk("r16_d3_dout", 32'(if3.dout), 0);
    chk("r16_d3_cnt", 32'(if3.digit_cnt), 3);
    // Largest digit as first digit of a new number: 15 mod 3 = 0
    cyc3(1, 1, 4'hf); chk("r16_max_rem", 32'(if3.rem), 0);
    chk("r16_max_dout", 32'(if3.dout), 1);
    chk("r16_max_cnt", 32'(if3.digit_cnt), 1);

    // 3-bit counter saturation, D=7: nine 1s = 511 = 7*73
    for (int i = 0; i < 6; i++) cyc7(0, 1, 1);
    chk("sat6_cnt", 32'(if7.digit_cnt), 6);
    chk("sat6_flag", 32'(if7.cnt_sat), 0);
    chk("sat6_rem", 32'(if7.rem), 0);
    cyc7(0, 1, 1);
    chk("sat7_cnt", 32'(if7.digit_cnt), 7);
    chk("sat7_flag", 32'(if7.cnt_sat), 1);
    chk("sat7_rem", 32'(if7.rem), 1);
    cyc7(0, 1, 1);
    cyc7(0, 1, 1);
    chk("sat9_cnt", 32'(if7.digit_cnt), 7);
    chk("sat9_flag", 32'(if7.cnt_sat), 1);
    chk("sat9_rem", 32'(if7.rem), 0);
    chk("sat9_dout", 32'(if7.dout), 1);
    cyc7(1, 0, 0);
    chk("sat_clr_flag", 32'(if7.cnt_sat), 0);
    chk("sat_clr_cnt", 32'(if7.digit_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
